mux_bus_arbiter: RTL
====================

// Module: mux_bus_arbiter
// PURPOSE
//  Shares the 32-bit 2:1 datapath MUX between two requesters.
//  Arbitrates round-robin with a bounded burst length and drives the MUX select.
//  Registers the winning word into a single output slot with valid/ready handshake.
//  Sits between two datapath sources and one consumer, e.g. a writeback/memory bus.
// PARAMETERS
//  WIDTH  32  data width of requester and output words
//  BURST  4   max consecutive transfers per tenure while the other side requests (>=1)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  req1       in   1      requester 1 has a word on data1
//  data1      in   WIDTH  requester 1 word
//  ack1       out  1      word on data1 accepted this cycle
//  req2       in   1      requester 2 has a word on data2
//  data2      in   WIDTH  requester 2 word
//  ack2       out  1      word on data2 accepted this cycle
//  sel        out  1      MUX select: 0 -> data1, 1 -> data2
//  out_data   out  WIDTH  registered selected word
//  out_valid  out  1      out_data holds an unconsumed word
//  out_ready  in   1      consumer takes out_data when out_valid & out_ready
//  owner      out  1      source of out_data: 0 = req1, 1 = req2
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, last=1 (req1 wins first tie),
//   out_valid=0, out_data=0, owner=0; sel=0, ack1=ack2=0 (combinational from state).
//  Reset mid-transfer: held word is discarded; no ack after release until regranted.
//  States: IDLE, GRANT1, GRANT2. sel=1 only in GRANT2.
//  slot_free = !out_valid | out_ready.
//  ackX = (state==GRANTX) & reqX & slot_free. Combinational, same cycle.
//  On ackX edge: out_data<=dataX, out_valid<=1, owner<=X-1.
//  Otherwise, if out_valid & out_ready: out_valid<=0 and out_data holds its value.
//  Requester rule: dataX stable while reqX & !ackX; reqX may drop before ack (withdraw).
//  IDLE: req1&req2 -> grant side != last; single req -> that side;
//   none -> stay. cnt<=0.
//  GRANTX (other side Y):
//   - !reqX -> GRANTY if reqY else IDLE; cnt<=0; last<=X.
//   - ackX & cnt==BURST-1 & reqY -> GRANTY; cnt<=0; last<=X.
//   - ackX & cnt==BURST-1 & !reqY -> stay GRANTX; cnt<=0 (new tenure).
//   - ackX otherwise -> cnt<=cnt+1.
//   - no ack (stall) -> hold state and cnt.
//  cnt width = clog2(BURST), min 1; cnt never exceeds BURST-1.
//  Latency: req in IDLE -> grant next edge -> ack that cycle -> out_valid next edge.
//   Sustained throughput: 1 word/cycle while out_ready=1.
//  Grant switch costs no bubble when the other side is already requesting.
//  Simultaneous consume + accept in one cycle: out_valid stays 1 with the new word.
//  ack1 & ack2 are never both 1. out_data changes only on ack.
// TESTING
//  1. rst_n=0 with random inputs -> all outputs 0, sel=0; after release, IDLE holds until req.
//  2. req1=1, data1=32'h1111_1111, out_ready=1 -> cycle1 ack1=1, cycle2 out_valid=1,
//     out_data=32'h1111_1111, owner=0.
//  3. BURST=4, req1=req2=1, out_ready=1 -> ack sequence 1,1,1,1,2,2,2,2,1...;
//     sel tracks the grant.
//  4. out_valid=1, out_ready=0 for 5 cycles -> ack1=ack2=0 and out_data stable;
//     out_ready=1 -> acks resume in the same cycle.
//  5. both requesting, req1 drops after 2 acks -> GRANT2 next edge, cnt=0,
//     then 4 req2 acks before returning to req1.
//  6. rst_n pulsed low mid-burst -> out_valid=0 at once; after release,
//     req1&req2 tie -> req1 granted first.

Source files
------------

// File: rtl/mux_bus_arbiter_if.sv
// Bundle for the two-requester / one-consumer arbiter bus.
// The master modport is the outside world, the slave modport is the arbiter itself.
interface mux_bus_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack1;
  logic             req2;
  logic [WIDTH-1:0] data2;
  logic             ack2;
  logic             sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             owner;

  modport master (
    output req1, data1, req2, data2, out_ready,
    input  ack1, ack2, sel, out_data, out_valid, owner
  );

  modport slave (
    input  req1, data1, req2, data2, out_ready,
    output ack1, ack2, sel, out_data, out_valid, owner
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter with bounded burst that steers a 2:1 datapath MUX
// into a single registered output slot with a valid/ready handshake.
module mux_bus_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_bus_arbiter_if.slave    bus
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT1 = 2'd1;
  localparam logic [1:0] S_GRANT2 = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic [WIDTH-1:0] r_outData;
  logic             r_outValid;
  logic             r_owner;

  logic [1:0]       w_nextState;
  logic [CW-1:0]    w_nextCnt;
  logic             w_nextLast;
  logic             w_slotFree;
  logic             w_ack1;
  logic             w_ack2;
  logic             w_ack;
  logic             w_sel;
  logic [WIDTH-1:0] w_muxData;
  logic             w_reqMine;
  logic             w_reqOther;
  logic [1:0]       w_otherState;
  logic             w_cntLast;

  assign w_slotFree = !r_outValid || bus.out_ready;
  assign w_ack1     = (r_state == S_GRANT1) && bus.req1 && w_slotFree;
  assign w_ack2     = (r_state == S_GRANT2) && bus.req2 && w_slotFree;
  assign w_ack      = w_ack1 || w_ack2;
  assign w_sel      = (r_state == S_GRANT2);
  assign w_muxData  = w_sel ? bus.data2 : bus.data1;

  // The side currently granted versus the side waiting, seen from the grant states.
  assign w_reqMine    = w_sel ? bus.req2 : bus.req1;
  assign w_reqOther   = w_sel ? bus.req1 : bus.req2;
  assign w_otherState = w_sel ? S_GRANT1 : S_GRANT2;
  assign w_cntLast    = (r_cnt == CW'(BURST - 1));

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextLast  = r_last;
    case (r_state)
      S_IDLE: begin
        w_nextCnt = '0;
        if (bus.req1 && bus.req2) begin
          w_nextState = r_last ? S_GRANT1 : S_GRANT2;
        end else if (bus.req1) begin
          w_nextState = S_GRANT1;
        end else if (bus.req2) begin
          w_nextState = S_GRANT2;
        end
      end
      S_GRANT1, S_GRANT2: begin
        if (!w_reqMine) begin
          w_nextState = w_reqOther ? w_otherState : S_IDLE;
          w_nextCnt   = '0;
          w_nextLast  = w_sel;
        end else if (w_ack) begin
          if (w_cntLast) begin
            // A full burst with nobody waiting just starts a fresh tenure.
            w_nextCnt = '0;
            if (w_reqOther) begin
              w_nextState = w_otherState;
              w_nextLast  = w_sel;
            end
          end else begin
            w_nextCnt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_last  <= w_nextLast;
    end
  end

  // Accepting a new word takes priority; a consume that coincides keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_owner    <= 1'b0;
    end else if (w_ack) begin
      r_outData  <= w_muxData;
      r_outValid <= 1'b1;
      r_owner    <= w_sel;
    end else if (r_outValid && bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.ack1      = w_ack1;
  assign bus.ack2      = w_ack2;
  assign bus.sel       = w_sel;
  assign bus.out_data  = r_outData;
  assign bus.out_valid = r_outValid;
  assign bus.owner     = r_owner;

endmodule
